vital_alarm_ctrl: RTL and testbench

- Downstream consumer of the smart-ring vital-sign comparator stage. It takes that stage's emergency flag (E) and oxygen-deficit byte (D) once per sensor sample.
- Confirms an emergency only after consecutive flagged samples, then drives the alarm, a patterned buzzer and a timed oxygen-valve dose.
- Clears itself only after sustained normal readings and once the dose has finished. Provides a user acknowledge/silence input and a saturating event counter.

---
 rtl/vital_alarm_ctrl.sv | 147 ++++++++++++++
 tb/tb_vital_alarm_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vital_alarm_ctrl.sv
// Alarm controller behind the vital-sign comparator stage.
// It confirms emergencies, drives the patterned buzzer and a timed O2 dose, and counts confirmed events.
module vital_alarm_ctrl #(
    parameter int CONFIRM_SAMPLES  = 3,
    parameter int CLEAR_SAMPLES    = 4,
    parameter int BUZZ_HALF_PERIOD = 8,
    parameter int DOSE_SHIFT       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic       emerg_in,
    input  logic [7:0] o2_deficit,
    input  logic       user_ack,
    output logic       alarm_on,
    output logic       buzzer,
    output logic       valve_open,
    output logic       silenced,
    output logic [1:0] state,
    output logic [7:0] event_count
);
    localparam int DW = 8 + DOSE_SHIFT;
    localparam int BW = (BUZZ_HALF_PERIOD > 1) ? $clog2(BUZZ_HALF_PERIOD) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CONFIRM = 2'b01,
        ALARM   = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      conf_cnt_q, conf_cnt_d;
    logic [3:0]      clr_cnt_q, clr_cnt_d;
    logic [DW-1:0]   dose_cnt_q, dose_cnt_d;
    logic [BW-1:0]   buzz_cnt_q, buzz_cnt_d;
    logic            buzzer_q, buzzer_d;
    logic            silenced_q, silenced_d;
    logic [7:0]      event_q, event_d;
    logic            enter;
    logic            buzz_wrap;

    assign buzz_wrap = (buzz_cnt_q == BW'(BUZZ_HALF_PERIOD - 1));

    always_comb begin
        state_d    = state_q;
        conf_cnt_d = conf_cnt_q;
        clr_cnt_d  = clr_cnt_q;
        dose_cnt_d = dose_cnt_q;
        buzz_cnt_d = buzz_cnt_q;
        buzzer_d   = buzzer_q;
        silenced_d = silenced_q;
        event_d    = event_q;
        enter      = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_valid && emerg_in) begin
                    if (CONFIRM_SAMPLES == 1) begin
                        enter = 1'b1;
                    end else begin
                        state_d    = CONFIRM;
                        conf_cnt_d = 4'd1;
                    end
                end
            end
            CONFIRM: begin
                if (sample_valid) begin
                    if (!emerg_in) begin
                        state_d    = IDLE;
                        conf_cnt_d = 4'd0;
                    end else if (conf_cnt_q + 4'd1 == 4'(CONFIRM_SAMPLES)) begin
                        enter = 1'b1;
                    end else begin
                        conf_cnt_d = conf_cnt_q + 4'd1;
                    end
                end
            end
            ALARM: begin
                // A running dose is never touched; only an exhausted one may reload.
                if (dose_cnt_q != '0)
                    dose_cnt_d = dose_cnt_q - DW'(1);
                else if (sample_valid && emerg_in)
                    dose_cnt_d = DW'(o2_deficit) << DOSE_SHIFT;
                if (sample_valid) begin
                    if (emerg_in)
                        clr_cnt_d = 4'd0;
                    else if (clr_cnt_q != 4'(CLEAR_SAMPLES))
                        clr_cnt_d = clr_cnt_q + 4'd1;
                end
                if (user_ack)
                    silenced_d = 1'b1;
                buzz_cnt_d = buzz_wrap ? '0 : buzz_cnt_q + BW'(1);
                if (silenced_q || user_ack)
                    buzzer_d = 1'b0;
                else if (buzz_wrap)
                    buzzer_d = ~buzzer_q;
                if (clr_cnt_d == 4'(CLEAR_SAMPLES) && dose_cnt_q == '0) begin
                    state_d    = IDLE;
                    clr_cnt_d  = 4'd0;
                    silenced_d = 1'b0;
                    buzzer_d   = 1'b0;
                    buzz_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter) begin
            state_d    = ALARM;
            conf_cnt_d = 4'd0;
            clr_cnt_d  = 4'd0;
            dose_cnt_d = DW'(o2_deficit) << DOSE_SHIFT;
            silenced_d = 1'b0;
            buzzer_d   = 1'b1;
            buzz_cnt_d = '0;
            if (event_q != 8'hFF)
                event_d = event_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            conf_cnt_q <= '0;
            clr_cnt_q  <= '0;
            dose_cnt_q <= '0;
            buzz_cnt_q <= '0;
            buzzer_q   <= 1'b0;
            silenced_q <= 1'b0;
            event_q    <= '0;
        end else begin
            state_q    <= state_d;
            conf_cnt_q <= conf_cnt_d;
            clr_cnt_q  <= clr_cnt_d;
            dose_cnt_q <= dose_cnt_d;
            buzz_cnt_q <= buzz_cnt_d;
            buzzer_q   <= buzzer_d;
            silenced_q <= silenced_d;
            event_q    <= event_d;
        end
    end

    assign alarm_on    = (state_q == ALARM);
    assign buzzer      = buzzer_q;
    assign valve_open  = (dose_cnt_q != '0);
    assign silenced    = silenced_q;
    assign state       = state_q;
    assign event_count = event_q;
endmodule

// File: tb/tb_vital_alarm_ctrl.sv
// Scoreboard bench for vital_alarm_ctrl: a per-edge reference model queues expected outputs.
// A monitor compares those against the DUT just after each edge.
module tb_vital_alarm_ctrl;
    localparam int CONF = 3, CLEAR = 4, HALF = 8, DS = 2;

    logic       clk = 0, rst = 1;
    logic       sample_valid = 0, emerg_in = 0, user_ack = 0;
    logic [7:0] o2_deficit = 0;
    logic       alarm_on, buzzer, valve_open, silenced;
    logic [1:0] state;
    logic [7:0] event_count;

    vital_alarm_ctrl #(.CONFIRM_SAMPLES(CONF), .CLEAR_SAMPLES(CLEAR),
                       .BUZZ_HALF_PERIOD(HALF), .DOSE_SHIFT(DS)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .emerg_in(emerg_in),
        .o2_deficit(o2_deficit), .user_ack(user_ack), .alarm_on(alarm_on),
        .buzzer(buzzer), .valve_open(valve_open), .silenced(silenced),
        .state(state), .event_count(event_count));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       alarm, buzz, valve, sil;
        logic [7:0] evt;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0, failures = 0;

    // Reference model: plain integers, buzzer derived from time spent in ALARM.
    int m_state = 0, m_conf = 0, m_clr = 0, m_dose = 0, m_evt = 0, m_t = 0;
    bit m_sil = 0;

    function automatic obs_t model_obs();
        obs_t o;
        o.st    = 2'(m_state);
        o.alarm = (m_state == 2);
        o.buzz  = (m_state == 2) && !m_sil && (((m_t / HALF) % 2) == 0);
        o.valve = (m_dose > 0);
        o.sil   = m_sil;
        o.evt   = 8'(m_evt);
        return o;
    endfunction

    task automatic m_enter(input int d);
        m_state = 2; m_conf = 0; m_clr = 0; m_sil = 0; m_t = 0;
        m_dose  = d * (1 << DS);
        if (m_evt < 255) m_evt++;
    endtask

    always @(posedge clk) begin
        int old_dose;
        if (rst) begin
            m_state = 0; m_conf = 0; m_clr = 0; m_dose = 0; m_evt = 0; m_t = 0; m_sil = 0;
        end else if (m_state == 0) begin
            if (sample_valid && emerg_in) begin
                if (CONF == 1) m_enter(int'(o2_deficit));
                else begin m_state = 1; m_conf = 1; end
            end
        end else if (m_state == 1) begin
            if (sample_valid) begin
                if (!emerg_in) begin m_state = 0; m_conf = 0; end
                else begin
                    m_conf++;
                    if (m_conf == CONF) m_enter(int'(o2_deficit));
                end
            end
        end else begin
            old_dose = m_dose;
            if (m_dose > 0) m_dose--;
            else if (sample_valid && emerg_in) m_dose = int'(o2_deficit) * (1 << DS);
            if (sample_valid) m_clr = emerg_in ? 0 : ((m_clr < CLEAR) ? m_clr + 1 : CLEAR);
            if (user_ack) m_sil = 1;
            m_t++;
            if (m_clr == CLEAR && old_dose == 0) begin
                m_state = 0; m_clr = 0; m_sil = 0; m_t = 0;
            end
        end
        exp_q.push_back(model_obs());
    end

    always @(posedge clk) begin
        obs_t e, a;
        #1;
        a = '{st: state, alarm: alarm_on, buzz: buzzer, valve: valve_open, sil: silenced, evt: event_count};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty t=%0t got=%h", $time, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                failures++;
                $display("FAIL outputs t=%0t got st=%0d al=%0b bz=%0b vo=%0b si=%0b ev=%0d want st=%0d al=%0b bz=%0b vo=%0b si=%0b ev=%0d",
                         $time, a.st, a.alarm, a.buzz, a.valve, a.sil, a.evt,
                         e.st, e.alarm, e.buzz, e.valve, e.sil, e.evt);
            end
        end
    end

    task automatic drive(input bit sv, input bit e, input int d, input bit ack);
        sample_valid = sv; emerg_in = e; o2_deficit = 8'(d); user_ack = ack;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
    endtask

    task automatic smp(input bit e, input int d);
        drive(1, e, d, 0);
        drive(0, 0, 0, 0);
    endtask

    task automatic clear4();
        for (int i = 0; i < 4; i++) smp(0, 0);
    endtask

    initial begin
        bit mode;
        @(negedge clk);
        idle(3);
        rst = 0;
        idle(100);
        // Confirm path with 20-cycle dose and buzzer pattern
        smp(1, 5); smp(1, 5); smp(1, 5);
        idle(40);
        clear4();
        idle(5);
        // False alarm
        smp(1, 4); smp(1, 4); smp(0, 4);
        idle(5);
        // Ack during short dose, then clear
        smp(1, 2); smp(1, 2); smp(1, 2);
        idle(2);
        drive(0, 0, 0, 1);
        idle(12);
        clear4();
        idle(5);
        // Long dose blocks clearing; emergency mid-dose restarts the clear count
        smp(1, 200); smp(1, 200); smp(1, 200);
        clear4();
        idle(480);
        smp(1, 9);
        idle(20);
        clear4();
        idle(320);
        // Reload after exhausted dose, simultaneous sample and ack
        smp(1, 1); smp(1, 1); smp(1, 1);
        idle(10);
        drive(1, 1, 3, 1);
        idle(20);
        clear4();
        idle(3);
        // Asynchronous reset mid-dose
        smp(1, 50); smp(1, 50); smp(1, 50);
        idle(10);
        @(posedge clk); #2;
        rst = 1;
        #1;
        checks++;
        if ({state, alarm_on, buzzer, valve_open, silenced, event_count} !== 14'd0) begin
            failures++;
            $display("FAIL async_reset got=%b want=0", {state, alarm_on, buzzer, valve_open, silenced, event_count});
        end
        @(negedge clk);
        idle(2);
        rst = 0;
        idle(5);
        // Event counter saturation
        for (int ep = 0; ep < 260; ep++) begin
            smp(1, 0); smp(1, 0); smp(1, 0);
            clear4();
        end
        idle(5);
        // Randomized traffic with slowly changing emergency bias
        mode = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 150 == 0) mode = $urandom_range(0, 1);
            drive(($urandom % 3) == 0,
                  mode ? (($urandom % 8) != 0) : (($urandom % 8) == 0),
                  (($urandom % 5) == 0) ? 0 : int'($urandom_range(1, 20)),
                  ($urandom % 40) == 0);
        end
        idle(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
